// File: rtl/bus_register_file.sv
// Purpose: bank of DEPTH x WIDTH registers on a shared tri-state CPU bus, with load, drive, inc/dec, wrap and contention status.
// Latency: loads and counts land on the next posedge; value, zero and bus drive are combinational from the current contents.
// Backpressure: none; a simultaneous read+write request is refused and latched as a sticky conflict flag until reset.
module bus_register_file #(
    parameter int                   WIDTH           = 8,
    parameter int                   DEPTH           = 4,
    parameter logic [WIDTH-1:0]     BUS_OUTPUT_MASK = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]     RESET_VALUE     = '0,
    localparam int                  AW              = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    sel,
    input  logic             read_from_bus,
    input  logic             write_to_bus,
    input  logic             inc,
    input  logic             dec,
    inout  wire  [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             carry,
    output logic             conflict
);

    logic [WIDTH-1:0] regs [DEPTH];

    // sel can exceed the bank when DEPTH is not a power of two
    logic sel_valid;
    logic contention;
    logic do_load;
    logic do_inc;
    logic do_dec;
    logic drive_en;

    // Decode the control word into mutually exclusive actions
    always_comb begin
        sel_valid  = int'(sel) < DEPTH;
        contention = read_from_bus & write_to_bus;
        do_load    = read_from_bus & ~write_to_bus & sel_valid;
        do_inc     = inc & ~dec & sel_valid;
        do_dec     = dec & ~inc & sel_valid;
        drive_en   = write_to_bus & ~read_from_bus & sel_valid;
    end

    // Selected register contents, reading as zero for an out-of-range select
    always_comb begin
        value = '0;
        if (sel_valid) begin
            value = regs[sel];
        end
        zero = (value == '0);
    end

    // The bus carries the pre-update contents, so drive and count can share a microstep
    assign bus = drive_en ? (value & BUS_OUTPUT_MASK) : {WIDTH{1'bz}};

    // Register bank update: load beats count; inc+dec together is a hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (do_load) begin
            regs[sel] <= bus;
        end else if (do_inc) begin
            regs[sel] <= value + 1'b1;
        end else if (do_dec) begin
            regs[sel] <= value - 1'b1;
        end
    end

    // Wrap flag is shared by the whole bank and tracks the most recent load or count
    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (do_load) begin
            carry <= 1'b0;
        end else if (do_inc) begin
            carry <= (value == {WIDTH{1'b1}});
        end else if (do_dec) begin
            carry <= (value == '0);
        end
    end

    // Contention is sticky so a transient bus fight is never missed by the controller
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict <= 1'b0;
        end else if (contention) begin
            conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_register_file.sv
// Directed bench: full-mask 4-deep bank and a 0x0F-masked 3-deep bank share one control word.
// Each bench-owned bus is driven by the bench only when loading, and "not driven" is observed through the bank's drive enable.
// Expected values are hand-computed constants.
module tb_bus_register_file;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       read_from_bus;
    logic       write_to_bus;
    logic       inc;
    logic       dec;
    logic       tb_en;
    logic [7:0] tb_dat;

    wire  [7:0] bus_a;
    wire  [7:0] bus_m;
    logic [7:0] value_a, value_m;
    logic       zero_a, zero_m;
    logic       carry_a, carry_m;
    logic       conflict_a, conflict_m;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign bus_a = tb_en ? tb_dat : 8'hzz;
    assign bus_m = tb_en ? tb_dat : 8'hzz;

    bus_register_file #(
        .WIDTH(8), .DEPTH(4), .BUS_OUTPUT_MASK(8'hFF), .RESET_VALUE(8'h00)
    ) u_a (
        .clk(clk), .rst(rst), .sel(sel),
        .read_from_bus(read_from_bus), .write_to_bus(write_to_bus),
        .inc(inc), .dec(dec), .bus(bus_a),
        .value(value_a), .zero(zero_a), .carry(carry_a), .conflict(conflict_a)
    );

    bus_register_file #(
        .WIDTH(8), .DEPTH(3), .BUS_OUTPUT_MASK(8'h0F), .RESET_VALUE(8'h00)
    ) u_m (
        .clk(clk), .rst(rst), .sel(sel),
        .read_from_bus(read_from_bus), .write_to_bus(write_to_bus),
        .inc(inc), .dec(dec), .bus(bus_m),
        .value(value_m), .zero(zero_m), .carry(carry_m), .conflict(conflict_m)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, leaving inputs to be changed 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_from_bus = 1'b0;
        write_to_bus  = 1'b0;
        inc           = 1'b0;
        dec           = 1'b0;
        tb_en         = 1'b0;
        tb_dat        = 8'h00;
    endtask

    task automatic load(input logic [1:0] s, input logic [7:0] d);
        idle();
        sel           = s;
        read_from_bus = 1'b1;
        tb_en         = 1'b1;
        tb_dat        = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        sel = 2'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("reset_value_r%0d", s), value_a, 8'h00);
            chk($sformatf("reset_zero_r%0d", s), {7'd0, zero_a}, 8'h01);
        end
        chk("reset_carry", {7'd0, carry_a}, 8'h00);
        chk("reset_conflict", {7'd0, conflict_a}, 8'h00);
        chk("reset_bus_undriven", {7'd0, u_a.drive_en}, 8'h00);

        // Load and drive isolation
        load(2'd1, 8'hA5);
        load(2'd2, 8'h3C);
        write_to_bus = 1'b1;
        sel = 2'd1;
        #1;
        chk("drive_r1_bus", bus_a, 8'hA5);
        chk("drive_r1_enable", {7'd0, u_a.drive_en}, 8'h01);
        chk("mask_r1_bus", bus_m, 8'h05);
        chk("mask_r1_value", value_m, 8'hA5);
        sel = 2'd2;
        #1;
        chk("drive_r2_bus", bus_a, 8'h3C);
        chk("mask_r2_bus", bus_m, 8'h0C);
        sel = 2'd3;
        #1;
        chk("oob_no_drive", {7'd0, u_m.drive_en}, 8'h00);
        chk("oob_value", value_m, 8'h00);
        chk("oob_zero", {7'd0, zero_m}, 8'h01);
        write_to_bus = 1'b0;
        sel = 2'd0;
        #1;
        chk("iso_r0", value_a, 8'h00);
        sel = 2'd3;
        #1;
        chk("iso_r3", value_a, 8'h00);

        // Load to an out-of-range select touches nothing in the 3-deep bank
        load(2'd3, 8'h55);
        #1;
        chk("load_r3", value_a, 8'h55);
        chk("oob_load_value", value_m, 8'h00);
        sel = 2'd2;
        #1;
        chk("oob_load_r2_kept", value_m, 8'h3C);

        // Wrap in both directions
        load(2'd0, 8'hFF);
        inc = 1'b1;
        tick();
        idle();
        #1;
        chk("inc_wrap_value", value_a, 8'h00);
        chk("inc_wrap_carry", {7'd0, carry_a}, 8'h01);
        chk("inc_wrap_zero", {7'd0, zero_a}, 8'h01);
        dec = 1'b1;
        tick();
        idle();
        #1;
        chk("dec_wrap_value", value_a, 8'hFF);
        chk("dec_wrap_carry", {7'd0, carry_a}, 8'h01);
        chk("dec_wrap_zero", {7'd0, zero_a}, 8'h00);
        dec = 1'b1;
        tick();
        idle();
        #1;
        chk("dec_value", value_a, 8'hFE);
        chk("dec_carry", {7'd0, carry_a}, 8'h00);
        chk("dec_mask_bank", value_m, 8'hFE);

        // Drive and increment in the same microstep
        load(2'd3, 8'h10);
        write_to_bus = 1'b1;
        inc = 1'b1;
        #1;
        chk("drive_inc_bus", bus_a, 8'h10);
        tick();
        idle();
        #1;
        chk("drive_inc_next", value_a, 8'h11);

        // Inc+dec holds, including the carry; load beats inc and clears carry
        load(2'd2, 8'hFF);
        inc = 1'b1;
        tick();
        idle();
        #1;
        chk("pre_hold_value", value_a, 8'h00);
        chk("pre_hold_carry", {7'd0, carry_a}, 8'h01);
        inc = 1'b1;
        dec = 1'b1;
        tick();
        idle();
        #1;
        chk("incdec_hold_value", value_a, 8'h00);
        chk("incdec_hold_carry", {7'd0, carry_a}, 8'h01);
        read_from_bus = 1'b1;
        inc = 1'b1;
        tb_en = 1'b1;
        tb_dat = 8'h20;
        tick();
        idle();
        #1;
        chk("load_inc_value", value_a, 8'h20);
        chk("load_inc_carry", {7'd0, carry_a}, 8'h00);

        // Contention: no drive, no load, sticky flag
        sel = 2'd1;
        read_from_bus = 1'b1;
        write_to_bus = 1'b1;
        #1;
        chk("contend_no_drive", {7'd0, u_a.drive_en}, 8'h00);
        tick();
        idle();
        #1;
        chk("contend_conflict", {7'd0, conflict_a}, 8'h01);
        chk("contend_value", value_a, 8'hA5);
        chk("contend_conflict_m", {7'd0, conflict_m}, 8'h01);
        for (int i = 0; i < 10; i++) tick();
        chk("conflict_sticky", {7'd0, conflict_a}, 8'h01);

        // Reset mid-operation with carry and conflict set
        load(2'd0, 8'hFF);
        inc = 1'b1;
        tick();
        idle();
        #1;
        chk("pre_rst_carry", {7'd0, carry_a}, 8'h01);
        rst = 1'b1;
        sel = 2'd1;
        read_from_bus = 1'b1;
        tb_en = 1'b1;
        tb_dat = 8'h77;
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_mid_conflict", {7'd0, conflict_a}, 8'h00);
        chk("rst_mid_carry", {7'd0, carry_a}, 8'h00);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("rst_mid_r%0d", s), value_a, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_register_file.md
Name: bus_register_file

Overview:
- Parametrised bank of DEPTH registers, each WIDTH bits, sharing one tri-stated CPU bus.
- Generalises the single 8-bit bus register used for A/B/IR/MAR:
  - address-selected register;
  - in-place increment/decrement;
  - wrap (carry) and zero status;
  - sticky bus-contention error flag.
- Sits on the main CPU bus. It is driven by control-word lines from the controller FSM.

Parameters:
- WIDTH, 8: register and bus width in bits.
- DEPTH, 4: number of registers; must be >= 2. The address width is AW = $clog2(DEPTH), a derived localparam.
- BUS_OUTPUT_MASK, {WIDTH{1'b1}}: ANDed with register contents whenever the block drives the bus. Example: 8'h0F for a 4-bit address field.
- RESET_VALUE, 0: value every register takes on reset.

Ports:
- clk  input  1  system clock. All state updates on posedge.
- rst  input  1  synchronous, active-high reset. Sampled on posedge clk; no asynchronous path.
- sel  input  AW  selects the register for load, drive, inc, dec and the value port.
- read_from_bus  input  1  load regs[sel] from bus.
- write_to_bus  input  1  drive regs[sel] onto bus.
- inc  input  1  regs[sel] <= regs[sel] + 1.
- dec  input  1  regs[sel] <= regs[sel] - 1.
- bus  inout  WIDTH  shared CPU bus.
- value  output  WIDTH  combinational regs[sel]; 0 if sel >= DEPTH.
- zero  output  1  combinational; 1 when value == 0.
- carry  output  1  registered wrap flag.
- conflict  output  1  registered sticky contention error.

Behaviour:
- Reset, on posedge clk with rst=1:
  - all regs <= RESET_VALUE; carry <= 0; conflict <= 0.
  - rst overrides every other input in the same cycle.
  - An inc/dec/load pending in that cycle is discarded.
- Per-cycle priority for regs[sel], when rst=0:
  1. load: read_from_bus=1 and write_to_bus=0 → regs[sel] <= bus; carry <= 0. inc/dec are ignored.
  2. count: no load, and exactly one of inc/dec is 1.
     - inc: regs[sel] <= regs[sel]+1, modulo 2^WIDTH. carry <= 1 iff old value == all-ones, else 0.
     - dec: regs[sel] <= regs[sel]-1, modulo 2^WIDTH. carry <= 1 iff old value == 0, else 0.
  3. otherwise hold; carry holds. inc=dec=1 means hold with no carry change.
- Registers not selected always hold.
- Load latency: 1 cycle; value shows the new contents after the posedge.
- Bus drive is combinational:
  - Condition: write_to_bus=1, read_from_bus=0 and sel < DEPTH.
  - When met, bus = regs[sel] & BUS_OUTPUT_MASK. Otherwise bus = 'z.
  - Drive may coincide with inc or dec. The bus shows the pre-update value; the register updates at the posedge. This supports PC-out-then-increment in one microstep.
- read_from_bus=1 and write_to_bus=1 together:
  - no load, no drive;
  - conflict <= 1 on the next posedge;
  - conflict stays 1 until rst;
  - inc/dec still apply per the priority rules.
- sel >= DEPTH (DEPTH not a power of 2):
  - no register changes; bus not driven; value=0, so zero=1; carry holds.
  - read_from_bus+write_to_bus still sets conflict.
- carry is not per-register. It reflects the last count or load on any register.

Test Plan:
- Reset then idle: assert rst 1 cycle; then read value for sel=0..3 → all 8'h00, zero=1, carry=0, conflict=0, bus='z.
- Load and drive isolation:
  - Load 8'hA5 into r1 and 8'h3C into r2.
  - With write_to_bus=1, sel=1: bus=8'hA5. With sel=2: bus=8'h3C. r0 and r3 stay 0.
  - Repeat with BUS_OUTPUT_MASK=8'h0F: bus=8'h05, while value still reads 8'hA5.
- Wrap:
  - Load r0=8'hFF, then inc → r0=8'h00, carry=1, zero=1.
  - Then dec → r0=8'hFF, carry=1.
  - Then dec → 8'hFE, carry=0.
- Simultaneous events:
  - Drive+inc on r3=8'h10 → bus=8'h10 that cycle; r3=8'h11 next cycle.
  - load+inc with bus=8'h20 → r=8'h20, carry=0.
  - inc+dec → hold.
- Contention:
  - read_from_bus=write_to_bus=1 for 1 cycle → bus='z, register unchanged, conflict=1.
  - conflict stays 1 after 10 idle cycles; clears only on rst.
- Reset mid-operation: rst=1 in the same cycle as load 8'h77 plus a pending conflict → regs=0, conflict=0, carry=0 next cycle.
